// File: rtl/code_lock_pkg.sv
// ---------------------------------------------------------------------------
// code_lock_pkg
// Shared definitions for the code lock: FSM state encoding, digit width,
// default 50 MHz timing constants and small helpers for digit handling.
// ---------------------------------------------------------------------------
package code_lock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRY   = 2'd1,
      OPEN    = 2'd2,
      LOCKOUT = 2'd3
   } lock_state_t;

   localparam int DIGIT_W = 2;

   // Defaults for a 50 MHz clock: 5 s entry timeout, 3 s open, 10 s lockout.
   localparam int DEF_TIMEOUT_CYCLES = 250_000_000;
   localparam int DEF_UNLOCK_CYCLES  = 150_000_000;
   localparam int DEF_LOCKOUT_CYCLES = 500_000_000;

   // Digit idx of the stored code; digit 0 sits in the two LSBs.
   function automatic logic [DIGIT_W-1:0] codeDigit(input logic [15:0] code,
                                                    input logic [3:0]  idx);
      return DIGIT_W'(code >> (32'(idx) * DIGIT_W));
   endfunction

   // Key index of a one-hot press; multi-bit presses are flagged elsewhere,
   // so the value returned for them does not matter.
   function automatic logic [DIGIT_W-1:0] keyToDigit(input logic [3:0] key);
      logic [DIGIT_W-1:0] digit;
      digit = '0;
      case (key)
         4'b0010: digit = 2'd1;
         4'b0100: digit = 2'd2;
         4'b1000: digit = 2'd3;
         default: digit = 2'd0;
      endcase
      return digit;
   endfunction

endpackage

// File: rtl/code_lock_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
// Up-counter shared by the ENTRY, OPEN and LOCKOUT states. It counts while
// enabled and parks at the terminal value, so it never wraps.
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   clear_i  in   restart the count from zero
//   enable_i in   count this cycle
//   limit_i  in   terminal count (interval length minus one)
//   done_o   out  terminal count reached while enabled
// ---------------------------------------------------------------------------
module interval_timer #(
   parameter int WIDTH = 29
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;

   // Clear has priority so a restart on the same edge as the expiry wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i && (count_q != limit_i)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign done_o = enable_i && (count_q == limit_i);

endmodule

// File: rtl/code_lock.sv
// ---------------------------------------------------------------------------
// code_lock
// Sequential code lock fed by one-cycle key press pulses. Each press enters
// one digit; after CODE_LEN digits the attempt either opens the lock for
// UNLOCK_CYCLES or raises a one-cycle error pulse. MAX_FAIL consecutive
// wrong attempts lock the keypad out for LOCKOUT_CYCLES.
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   key_pulse    in   press pulses, bit k means digit k
//   unlocked     out  lock open
//   error_pulse  out  one-cycle pulse on a wrong completed code
//   locked_out   out  lockout active
//   digit_count  out  digits entered in the current attempt
//   fail_count   out  consecutive wrong codes
// ---------------------------------------------------------------------------
module code_lock
   import code_lock_pkg::*;
#(
   parameter int          CODE_LEN       = 4,
   parameter logic [15:0] CODE           = 16'h00E4,
   parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int          UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
   parameter int          MAX_FAIL       = 3,
   parameter int          LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] key_pulse,
   output logic       unlocked,
   output logic       error_pulse,
   output logic       locked_out,
   output logic [3:0] digit_count,
   output logic [2:0] fail_count
);

   localparam int MAX_CYC_A = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
   localparam int MAX_CYC   = (MAX_CYC_A > LOCKOUT_CYCLES) ? MAX_CYC_A : LOCKOUT_CYCLES;
   localparam int TIMER_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   lock_state_t        state_q, state_d;
   logic [3:0]         digitCount_q, digitCount_d;
   logic [2:0]         failCount_q, failCount_d;
   logic               mismatch_q, mismatch_d;
   logic               unlocked_q, unlocked_d;
   logic               lockedOut_q, lockedOut_d;
   logic               errorPulse_q, errorPulse_d;

   logic               press, oneHot, digitMiss, attemptMiss;
   logic [2:0]         failNext;
   logic               timerClear, timerEnable, timerDone;
   logic [TIMER_W-1:0] timerLimit;

   // A multi-bit press still counts as a digit, but always a wrong one.
   assign press       = |key_pulse;
   assign oneHot      = press && ((key_pulse & (key_pulse - 4'd1)) == 4'd0);
   assign digitMiss   = !oneHot || (keyToDigit(key_pulse) != codeDigit(CODE, digitCount_q));
   assign attemptMiss = mismatch_q || digitMiss;
   assign failNext    = failCount_q + 3'd1;

   // The one timer serves all three timed states; pick the interval for
   // whichever state currently owns it.
   always_comb begin
      timerLimit = TIMER_W'(TIMEOUT_CYCLES - 1);
      case (state_q)
         OPEN:    timerLimit = TIMER_W'(UNLOCK_CYCLES - 1);
         LOCKOUT: timerLimit = TIMER_W'(LOCKOUT_CYCLES - 1);
         default: timerLimit = TIMER_W'(TIMEOUT_CYCLES - 1);
      endcase
   end

   assign timerEnable = (state_q != IDLE);

   interval_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (timerClear),
      .enable_i (timerEnable),
      .limit_i  (timerLimit),
      .done_o   (timerDone)
   );

   // Next-state logic. In IDLE/ENTRY a press is checked before the timeout
   // so a press on the expiry cycle is kept; in OPEN a press and an expiry
   // both just relock. Output registers are driven from the next state so
   // every output changes on the same edge as the state.
   always_comb begin
      state_d      = state_q;
      digitCount_d = digitCount_q;
      failCount_d  = failCount_q;
      mismatch_d   = mismatch_q;
      errorPulse_d = 1'b0;
      timerClear   = 1'b0;

      case (state_q)
         IDLE, ENTRY: begin
            if (press) begin
               if (digitCount_q == 4'(CODE_LEN - 1)) begin
                  digitCount_d = 4'd0;
                  mismatch_d   = 1'b0;
                  timerClear   = 1'b1;
                  if (!attemptMiss) begin
                     state_d     = OPEN;
                     failCount_d = 3'd0;
                  end else begin
                     errorPulse_d = 1'b1;
                     failCount_d  = failNext;
                     state_d      = (failNext == 3'(MAX_FAIL)) ? LOCKOUT : IDLE;
                  end
               end else begin
                  digitCount_d = digitCount_q + 4'd1;
                  mismatch_d   = attemptMiss;
                  state_d      = ENTRY;
                  timerClear   = 1'b1;
               end
            end else if ((state_q == ENTRY) && timerDone) begin
               state_d      = IDLE;
               digitCount_d = 4'd0;
               mismatch_d   = 1'b0;
            end
         end
         OPEN: begin
            if (press || timerDone) begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (timerDone) begin
               state_d     = IDLE;
               failCount_d = 3'd0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      unlocked_d  = (state_d == OPEN);
      lockedOut_d = (state_d == LOCKOUT);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         digitCount_q <= 4'd0;
         failCount_q  <= 3'd0;
         mismatch_q   <= 1'b0;
         unlocked_q   <= 1'b0;
         lockedOut_q  <= 1'b0;
         errorPulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digitCount_q <= digitCount_d;
         failCount_q  <= failCount_d;
         mismatch_q   <= mismatch_d;
         unlocked_q   <= unlocked_d;
         lockedOut_q  <= lockedOut_d;
         errorPulse_q <= errorPulse_d;
      end
   end

   assign unlocked    = unlocked_q;
   assign error_pulse = errorPulse_q;
   assign locked_out  = lockedOut_q;
   assign digit_count = digitCount_q;
   assign fail_count  = failCount_q;

endmodule

// File: tb/tb_code_lock.sv
// ---------------------------------------------------------------------------
// tb_code_lock
// Directed self-checking bench for code_lock with short timing parameters
// (timeout 20, unlock 10, lockout 30, MAX_FAIL 3, code 0,1,2,3).
// ---------------------------------------------------------------------------
module tb_code_lock;

   logic       clk;
   logic       reset_n;
   logic [3:0] key_pulse;
   logic       unlocked;
   logic       error_pulse;
   logic       locked_out;
   logic [3:0] digit_count;
   logic [2:0] fail_count;

   int compareCount;
   int mismatchCount;

   code_lock #(
      .CODE_LEN       (4),
      .CODE           (16'h00E4),
      .TIMEOUT_CYCLES (20),
      .UNLOCK_CYCLES  (10),
      .MAX_FAIL       (3),
      .LOCKOUT_CYCLES (30)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_pulse   (key_pulse),
      .unlocked    (unlocked),
      .error_pulse (error_pulse),
      .locked_out  (locked_out),
      .digit_count (digit_count),
      .fail_count  (fail_count)
   );

   // 100 MHz simulation clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle 1 ns past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One-cycle key pulse, sampled on the next rising edge.
   task automatic applyStimulus(input logic [3:0] key);
      key_pulse = key;
      tick();
      key_pulse = 4'd0;
   endtask

   task automatic enterCorrectCode();
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      applyStimulus(4'b0100);
      applyStimulus(4'b1000);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " unlocked"},    32'(unlocked),    32'd0);
      checkOutput({tag, " error_pulse"}, 32'(error_pulse), 32'd0);
      checkOutput({tag, " locked_out"},  32'(locked_out),  32'd0);
      checkOutput({tag, " digit_count"}, 32'(digit_count), 32'd0);
      checkOutput({tag, " fail_count"},  32'(fail_count),  32'd0);
   endtask

   initial begin
      int  highCycles;
      int  maxDigit;
      bit  sawError;

      compareCount  = 0;
      mismatchCount = 0;
      key_pulse     = 4'd0;
      reset_n       = 1'b0;

      // Reset state
      #3;
      checkAllZero("reset");
      idleCycles(2);
      reset_n = 1'b1;
      idleCycles(2);

      // Correct code, presses 3 cycles apart
      applyStimulus(4'b0001);
      checkOutput("ok digit1", 32'(digit_count), 32'd1);
      idleCycles(2);
      applyStimulus(4'b0010);
      checkOutput("ok digit2", 32'(digit_count), 32'd2);
      idleCycles(2);
      applyStimulus(4'b0100);
      checkOutput("ok digit3", 32'(digit_count), 32'd3);
      idleCycles(2);
      applyStimulus(4'b1000);
      checkOutput("ok unlocked", 32'(unlocked), 32'd1);
      checkOutput("ok digit reset", 32'(digit_count), 32'd0);
      checkOutput("ok fail", 32'(fail_count), 32'd0);
      highCycles = 0;
      sawError   = 1'b0;
      for (int i = 0; i < 50 && unlocked; i++) begin
         highCycles++;
         if (error_pulse) sawError = 1'b1;
         tick();
      end
      checkOutput("ok open length", 32'(highCycles), 32'd10);
      checkOutput("ok no error", 32'(sawError), 32'd0);

      // Wrong code 0,1,2,2
      enterCorrectCode_wrong1();
      checkOutput("wrong1 error", 32'(error_pulse), 32'd1);
      checkOutput("wrong1 fail", 32'(fail_count), 32'd1);
      checkOutput("wrong1 digit", 32'(digit_count), 32'd0);
      checkOutput("wrong1 unlocked", 32'(unlocked), 32'd0);
      checkOutput("wrong1 locked", 32'(locked_out), 32'd0);
      tick();
      checkOutput("wrong1 error one cycle", 32'(error_pulse), 32'd0);

      // Second and third wrong code -> lockout
      enterCorrectCode_wrong1();
      checkOutput("wrong2 fail", 32'(fail_count), 32'd2);
      checkOutput("wrong2 locked", 32'(locked_out), 32'd0);
      tick();
      enterCorrectCode_wrong1();
      checkOutput("wrong3 error", 32'(error_pulse), 32'd1);
      checkOutput("wrong3 locked", 32'(locked_out), 32'd1);
      checkOutput("wrong3 fail", 32'(fail_count), 32'd3);
      highCycles = 0;
      maxDigit   = 0;
      for (int i = 1; i < 100 && locked_out; i++) begin
         highCycles++;
         key_pulse = (i % 5 == 0) ? 4'b0001 : 4'b0000;
         tick();
         key_pulse = 4'd0;
         if (int'(digit_count) > maxDigit) maxDigit = int'(digit_count);
      end
      checkOutput("lockout length", 32'(highCycles), 32'd30);
      checkOutput("lockout ignores keys", 32'(maxDigit), 32'd0);
      checkOutput("lockout released", 32'(locked_out), 32'd0);
      checkOutput("lockout fail cleared", 32'(fail_count), 32'd0);

      // Timeout with a non-zero fail count
      enterCorrectCode_wrong1();
      tick();
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      idleCycles(19);
      checkOutput("timeout pending digit", 32'(digit_count), 32'd2);
      sawError = error_pulse;
      tick();
      checkOutput("timeout digit", 32'(digit_count), 32'd0);
      checkOutput("timeout no error", 32'(sawError | error_pulse), 32'd0);
      checkOutput("timeout fail kept", 32'(fail_count), 32'd1);

      // Press on the expiry cycle is accepted
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      idleCycles(19);
      applyStimulus(4'b0100);
      checkOutput("expiry press digit", 32'(digit_count), 32'd3);
      applyStimulus(4'b1000);
      checkOutput("expiry unlock", 32'(unlocked), 32'd1);
      checkOutput("expiry fail cleared", 32'(fail_count), 32'd0);

      // Press during OPEN relocks and is not counted
      tick();
      applyStimulus(4'b0001);
      checkOutput("relock unlocked", 32'(unlocked), 32'd0);
      checkOutput("relock digit", 32'(digit_count), 32'd0);

      // Multi-bit press as the third digit
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      applyStimulus(4'b0011);
      checkOutput("multibit digit", 32'(digit_count), 32'd3);
      applyStimulus(4'b1000);
      checkOutput("multibit error", 32'(error_pulse), 32'd1);
      checkOutput("multibit unlocked", 32'(unlocked), 32'd0);
      checkOutput("multibit fail", 32'(fail_count), 32'd1);
      tick();

      // Reset mid-entry
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      checkOutput("pre-reset digit", 32'(digit_count), 32'd2);
      reset_n = 1'b0;
      #1;
      checkAllZero("reset mid-entry");
      tick();
      reset_n = 1'b1;
      tick();

      // Reset mid-unlock
      enterCorrectCode();
      idleCycles(3);
      checkOutput("pre-reset unlocked", 32'(unlocked), 32'd1);
      reset_n = 1'b0;
      #1;
      checkAllZero("reset mid-unlock");
      tick();
      reset_n = 1'b1;
      tick();

      // Normal unlock after reset
      enterCorrectCode();
      checkOutput("post-reset unlock", 32'(unlocked), 32'd1);
      checkOutput("post-reset error", 32'(error_pulse), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

   // Wrong attempt 0,1,2,2.
   task automatic enterCorrectCode_wrong1();
      applyStimulus(4'b0001);
      applyStimulus(4'b0010);
      applyStimulus(4'b0100);
      applyStimulus(4'b0100);
   endtask

endmodule
